// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch controller for a combinational imem.
// Presents pc on imem_addr, captures the returned word one cycle later into a
// single registered output slot with a valid/ready handshake, and supports
// branch redirects, a halt instruction and end-of-memory handling.
// Optional feature macro: IMEM_FETCH_WRAP_EN (wrap pc to 0 past the last word
// instead of halting with fault).
module imem_fetch_ctrl #(
  parameter int unsigned    N         = 16,
  parameter int unsigned    R         = 5,
  parameter logic [R-1:0]   RESET_PC  = '0,
  parameter logic [N-1:0]   HALT_WORD = 16'hFFFF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [R-1:0] imem_addr,
  input  logic [N-1:0] imem_rdata,
  output logic [N-1:0] instr,
  output logic [R-1:0] instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         redirect_valid,
  input  logic [R-1:0] redirect_addr,
  output logic         halted,
  output logic         fault,
  output logic [15:0]  fetch_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [R-1:0] LAST_PC = '1;

  state_t       state_q;
  logic [R-1:0] pc_q;
  logic [N-1:0] instr_q;
  logic [R-1:0] instr_pc_q;
  logic         instr_valid_q;
  logic         fault_q;
  logic [15:0]  fetch_count_q;
  logic [15:0]  fetch_count_d;

  logic handshake;
  logic slot_free;

  assign handshake = instr_valid_q & instr_ready;
  assign slot_free = ~instr_valid_q | handshake;

  // Count delivered words, sticking at all-ones instead of rolling over.
  always_comb begin
    fetch_count_d = fetch_count_q;
    if (handshake && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  // Fetch state machine together with pc, the output slot and the fault flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      case (state_q)
        IDLE: begin
          if (handshake) begin
            instr_valid_q <= 1'b0;
          end
          if (start) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          if (redirect_valid) begin
            pc_q          <= redirect_addr;
            instr_valid_q <= 1'b0;
          end else if (slot_free) begin
            instr_q       <= imem_rdata;
            instr_pc_q    <= pc_q;
            instr_valid_q <= 1'b1;
            if (imem_rdata == HALT_WORD) begin
              state_q <= HALTED;
            end else if (pc_q == LAST_PC) begin
`ifdef IMEM_FETCH_WRAP_EN
              pc_q <= '0;
`else
              state_q <= HALTED;
              fault_q <= 1'b1;
`endif
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end
        end
        HALTED: begin
          if (handshake) begin
            instr_valid_q <= 1'b0;
          end
          if (start) begin
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = (state_q == HALTED);
  assign fault       = fault_q;
  assign fetch_count = fetch_count_q;

endmodule
